// File: rtl/lfsr_monitor.sv
// Checker for the 3-bit LFSR: predicts each next state, tracks lock, counts
// sequence errors, flags the all-zero lock-up state and measures the period.
module lfsr_monitor #(
    parameter int LOCK_RUN = 3,
    parameter int ERRW     = 8
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic            L,
    input  logic [0:2]      Q,
    output logic            Sync,
    output logic            Err,
    output logic [ERRW-1:0] ErrCount,
    output logic [3:0]      Period,
    output logic            PeriodValid,
    output logic            Stuck
);

    localparam int RUNW = (LOCK_RUN > 2) ? $clog2(LOCK_RUN) : 1;
    localparam logic [RUNW-1:0] RUN_LAST = RUNW'(LOCK_RUN - 1);

    typedef enum logic {ACQ = 1'b0, LOCK = 1'b1} state_e;

    function automatic logic [0:2] lfsr_next(input logic [0:2] q);
        return {q[1] ^ q[2], q[0], q[1]};
    endfunction

    state_e          state_q, state_d;
    logic [0:2]      qp_q, qp_d;
    logic            have_p_q, have_p_d;
    logic [RUNW-1:0] run_q, run_d;
    logic [0:2]      seed_q, seed_d;
    logic [3:0]      pcnt_q, pcnt_d;
    logic            sync_q, sync_d;
    logic            err_q, err_d;
    logic [ERRW-1:0] err_cnt_q, err_cnt_d;
    logic [3:0]      period_q, period_d;
    logic            pvalid_q, pvalid_d;
    logic            stuck_q, stuck_d;

    logic match;
    logic run_done;

    assign match    = have_p_q && (Q == lfsr_next(qp_q));
    assign run_done = (run_q == RUN_LAST);

    always_comb begin
        state_d = state_q;
        if (L) begin
            state_d = ACQ;
        end else begin
            case (state_q)
                ACQ:     if (match && run_done) state_d = LOCK;
                LOCK:    if (!match)            state_d = ACQ;
                default: state_d = ACQ;
            endcase
        end
    end

    // NOTE: every signal gets its hold value first, so no path leaves one unassigned (no latches).
    always_comb begin
        qp_d      = qp_q;
        have_p_d  = have_p_q;
        run_d     = run_q;
        seed_d    = seed_q;
        pcnt_d    = pcnt_q;
        sync_d    = sync_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        period_d  = period_q;
        pvalid_d  = pvalid_q;
        stuck_d   = stuck_q;

        if (L) begin
            // A reload resynchronises but keeps the error history and last period.
            have_p_d = 1'b0;
            run_d    = '0;
            pcnt_d   = '0;
            pvalid_d = 1'b0;
            sync_d   = 1'b0;
        end else begin
            qp_d     = Q;
            have_p_d = 1'b1;
            stuck_d  = (Q == 3'b000);
            case (state_q)
                ACQ: begin
                    if (have_p_q) begin
                        if (!match) begin
                            run_d = '0;
                        end else if (run_done) begin
                            sync_d = 1'b1;
                            seed_d = Q;
                            pcnt_d = '0;
                            run_d  = '0;
                        end else begin
                            run_d = run_q + 1'b1;
                        end
                    end
                end
                LOCK: begin
                    if (!match) begin
                        err_d     = 1'b1;
                        err_cnt_d = (err_cnt_q == {ERRW{1'b1}}) ? err_cnt_q : err_cnt_q + 1'b1;
                        sync_d    = 1'b0;
                        run_d     = '0;
                        pvalid_d  = 1'b0;
                        pcnt_d    = '0;
                    end else if (Q == seed_q) begin
                        period_d = pcnt_q + 4'd1;
                        pvalid_d = 1'b1;
                        pcnt_d   = '0;
                    end else begin
                        pcnt_d = (pcnt_q == 4'd15) ? 4'd15 : pcnt_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= ACQ;
            qp_q      <= '0;
            have_p_q  <= 1'b0;
            run_q     <= '0;
            seed_q    <= '0;
            pcnt_q    <= '0;
            sync_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            period_q  <= '0;
            pvalid_q  <= 1'b0;
            stuck_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            qp_q      <= qp_d;
            have_p_q  <= have_p_d;
            run_q     <= run_d;
            seed_q    <= seed_d;
            pcnt_q    <= pcnt_d;
            sync_q    <= sync_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            period_q  <= period_d;
            pvalid_q  <= pvalid_d;
            stuck_q   <= stuck_d;
        end
    end

    assign Sync        = sync_q;
    assign Err         = err_q;
    assign ErrCount    = err_cnt_q;
    assign Period      = period_q;
    assign PeriodValid = pvalid_q;
    assign Stuck       = stuck_q;

endmodule
